// File: rtl/display_pkg.sv
// Shared definitions for the MAX7219 display sequencer.
// Holds the register map, the init list constants, list lengths, the word
// payload layout and the sequencer state encoding.
package display_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned DIGITS    = 8;
    localparam int unsigned INIT_LEN  = 5;
    localparam int unsigned FRAME_LEN = 9;

    // MAX7219 register addresses
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    // One 16-bit word as shifted out to the MAX7219
    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] addr;
        logic [7:0] data;
    } max_word_t;

    function automatic logic [WORD_W-1:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
        max_word_t w;
        w.rsvd = 4'h0;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Fixed init words; the scan-limit word depends on a parameter and is built in the mux
    localparam logic [WORD_W-1:0] INIT_SHUTDOWN   = 16'h0C00;
    localparam logic [WORD_W-1:0] INIT_TEST_OFF   = 16'h0F00;
    localparam logic [WORD_W-1:0] INIT_DECODE_ALL = 16'h09FF;
    localparam logic [WORD_W-1:0] INIT_RUN        = 16'h0C01;

    typedef enum logic [2:0] {
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP,
        ST_NEXT,
        ST_IDLE,
        ST_FRAME
    } state_e;

endpackage

// File: rtl/display_seq_ctrl_if.sv
// Word handshake between the display sequencer and the 16-bit SPI master.
//   spi_cs    sequencer -> master, low = send spi_word
//   spi_word  sequencer -> master, word to shift out
//   spi_send  master -> sequencer, word has been shifted out
//   spi_ready master -> sequencer, master idle and has seen CS high
interface display_seq_ctrl_if;
    logic        spi_cs;
    logic [15:0] spi_word;
    logic        spi_send;
    logic        spi_ready;

    modport master (output spi_cs, output spi_word, input spi_send, input spi_ready);
    modport slave  (input spi_cs, input spi_word, output spi_send, output spi_ready);
endinterface

// File: rtl/display_word_mux.sv
// Combinational word selector: maps (list, index) to the 16-bit word to send.
// Build option BLANK_LEADING_EN: when defined, leading zero digits 7..1 are
// sent as code-B blank (4'hF); digit 0 is never blanked, dp is untouched.
//   in_init    1 = init list, 0 = display frame
//   idx        word index within the list
//   digits     snapshot BCD digits, digit i at [4i+3:4i]
//   dp         snapshot decimal points
//   intensity  snapshot brightness
//   word_c     selected word
module display_word_mux
    import display_pkg::*;
#(
    parameter int unsigned SCAN_LIMIT = 7
) (
    input  logic                 in_init,
    input  logic [IDX_W-1:0]     idx,
    input  logic [4*DIGITS-1:0]  digits,
    input  logic [DIGITS-1:0]    dp,
    input  logic [3:0]           intensity,
    output logic [WORD_W-1:0]    word_c
);

    logic [DIGITS-1:0] blank_c;

`ifdef BLANK_LEADING_EN
    // Blank from the top digit down until the first nonzero digit
    always_comb begin
        logic run;
        run     = 1'b1;
        blank_c = '0;
        for (int i = 7; i >= 1; i--) begin
            if (digits[4*i +: 4] != 4'h0) begin
                run = 1'b0;
            end
            blank_c[i] = run;
        end
    end
`else
    assign blank_c = '0;
`endif

    // Frame word k (1..8) carries digit k-1
    always_comb begin
        logic [2:0] sel;
        logic [3:0] bcd;
        sel    = 3'(idx - 4'd1);
        bcd    = blank_c[sel] ? 4'hF : digits[{sel, 2'b00} +: 4];
        word_c = '0;
        if (in_init) begin
            case (idx)
                4'd0:    word_c = INIT_SHUTDOWN;
                4'd1:    word_c = INIT_TEST_OFF;
                4'd2:    word_c = INIT_DECODE_ALL;
                4'd3:    word_c = mk_word(REG_SCANLIM, 8'(SCAN_LIMIT));
                4'd4:    word_c = INIT_RUN;
                default: word_c = '0;
            endcase
        end else if (idx == 4'd0) begin
            word_c = mk_word(REG_INTENSITY, {4'h0, intensity});
        end else if (idx <= 4'(DIGITS)) begin
            word_c = mk_word(idx, {dp[sel], 3'b000, bcd});
        end
    end

endmodule

// File: rtl/display_seq_ctrl.sv
// Sequencer for the SPI master driving a MAX7219 8-digit display.
// Sends the init list after reset, then one frame (intensity + 8 digits)
// per update strobe; strobes arriving while busy coalesce into one frame.
// Build option BLANK_LEADING_EN selects leading-zero blanking (see display_word_mux).
//   clk, res    clock, synchronous active-high reset
//   update      1-cycle strobe requesting a frame
//   digits/dp/intensity  display content, snapshotted at frame start
//   spi         word handshake to the SPI master (master modport)
//   busy        init or frame in progress
//   init_done   init list completed, held until reset
module display_seq_ctrl
    import display_pkg::*;
#(
    parameter int unsigned CS_HIGH_CYCLES = 4,
    parameter int unsigned SCAN_LIMIT     = 7
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      update,
    input  logic [4*DIGITS-1:0]       digits,
    input  logic [DIGITS-1:0]         dp,
    input  logic [3:0]                intensity,
    display_seq_ctrl_if.master        spi,
    output logic                      busy,
    output logic                      init_done
);

    localparam int unsigned      GAP_W      = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(INIT_LEN - 1);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                in_init_q, in_init_d;
    logic                pending_q, pending_d;
    logic                spi_cs_q, spi_cs_d;
    logic [WORD_W-1:0]   spi_word_q, spi_word_d;
    logic                busy_q, busy_d;
    logic                init_done_q, init_done_d;
    logic [4*DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [3:0]          snap_int_q, snap_int_d;

    logic [WORD_W-1:0]   word_c;
    logic [IDX_W-1:0]    last_idx_c;
    logic                sent_c;

    assign last_idx_c = in_init_q ? INIT_LAST : FRAME_LAST;
    // spi_send only counts once CS is actually low for this word
    assign sent_c     = !spi_cs_q && spi.spi_send;

    display_word_mux #(
        .SCAN_LIMIT (SCAN_LIMIT)
    ) u_word_mux (
        .in_init   (in_init_q),
        .idx       (idx_q),
        .digits    (snap_digits_q),
        .dp        (snap_dp_q),
        .intensity (snap_int_q),
        .word_c    (word_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= ST_WAIT_RDY;
            idx_q         <= '0;
            gap_q         <= '0;
            in_init_q     <= 1'b1;
            pending_q     <= 1'b0;
            spi_cs_q      <= 1'b1;
            spi_word_q    <= '0;
            busy_q        <= 1'b1;
            init_done_q   <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_int_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            in_init_q     <= in_init_d;
            pending_q     <= pending_d;
            spi_cs_q      <= spi_cs_d;
            spi_word_q    <= spi_word_d;
            busy_q        <= busy_d;
            init_done_q   <= init_done_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_int_q    <= snap_int_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_RDY: if (spi.spi_ready && gap_q == '0) state_d = ST_SEND;
            ST_SEND:     if (sent_c) state_d = ST_GAP;
            ST_GAP:      if (gap_q == '0) state_d = ST_NEXT;
            ST_NEXT: begin
                if (idx_q != last_idx_c) begin
                    state_d = ST_WAIT_RDY;
                end else if (pending_q || update) begin
                    state_d = ST_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE:     if (update || pending_q) state_d = ST_FRAME;
            ST_FRAME:    state_d = ST_WAIT_RDY;
            default:     state_d = ST_WAIT_RDY;
        endcase
    end

    // Registered outputs and datapath updates
    always_comb begin
        spi_cs_d      = spi_cs_q;
        spi_word_d    = spi_word_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        in_init_d     = in_init_q;
        init_done_d   = init_done_q;
        pending_d     = pending_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_int_d    = snap_int_q;
        busy_d        = (state_d != ST_IDLE);

        // IDLE serves a strobe directly, everywhere else it is queued
        if (update && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_WAIT_RDY: begin
                spi_cs_d = 1'b1;
                // Word settles one cycle before CS is allowed to fall in SEND
                if (state_d == ST_SEND) begin
                    spi_word_d = word_c;
                end
            end
            ST_SEND: begin
                if (sent_c) begin
                    spi_cs_d = 1'b1;
                    gap_d    = GAP_W'(CS_HIGH_CYCLES);
                end else if (spi.spi_ready) begin
                    spi_cs_d = 1'b0;
                end
            end
            ST_GAP: begin
                spi_cs_d = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_NEXT: begin
                if (idx_q == last_idx_c) begin
                    idx_d = '0;
                    if (in_init_q) begin
                        init_done_d = 1'b1;
                        in_init_d   = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                spi_cs_d = 1'b1;
            end
            ST_FRAME: begin
                snap_digits_d = digits;
                snap_dp_d     = dp;
                snap_int_d    = intensity;
                pending_d     = update;
                idx_d         = '0;
                in_init_d     = 1'b0;
            end
            default: begin
                spi_cs_d = 1'b1;
            end
        endcase
    end

    assign spi.spi_cs   = spi_cs_q;
    assign spi.spi_word = spi_word_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;

endmodule
